c11_bist_ctrl: RTL

C11_BIST_CTRL -- requirements
Module: c11_bist_ctrl

---
 rtl/c11_bist_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/c11_bist_ctrl.sv
// c11_bist_ctrl -- BIST sequencer for a pair of C11 instances (golden vs CUT).
// Generates 10-bit test patterns (exhaustive counter or x^10+x^7+1 LFSR),
// allows one settle cycle per pattern, then compares golden_in and cut_in,
// counts mismatches, records the first failing index, and folds cut_in into
// a 16-bit MISR.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start, abort      run control (start honoured only in IDLE)
//   mode, seed,       run configuration, latched when start is accepted
//   num_pat           (num_pat=0 means 1024 patterns)
//   golden_in, cut_in responses of the two C11 instances
//   pattern           stimulus to both instances (bit 0 = G1gat)
//   busy, done        status (done is a one-cycle pulse)
//   mism_cnt, first_fail_idx, first_fail_vld, signature  run results
module c11_bist_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        mode,
  input  logic [9:0]  seed,
  input  logic [9:0]  num_pat,
  input  logic        golden_in,
  input  logic        cut_in,
  output logic [9:0]  pattern,
  output logic        busy,
  output logic        done,
  output logic [10:0] mism_cnt,
  output logic [9:0]  first_fail_idx,
  output logic        first_fail_vld,
  output logic [15:0] signature
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    APPLY  = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        mode_q, mode_d;
  logic [9:0]  num_q, num_d;
  logic [9:0]  seed_q, seed_d;
  logic [9:0]  pat_q, pat_d;
  logic [9:0]  idx_q, idx_d;
  logic [10:0] mism_q, mism_d;
  logic [9:0]  ffi_q, ffi_d;
  logic        ffv_q, ffv_d;
  logic [15:0] sig_q, sig_d;

  logic        last_pat;
  logic [9:0]  pat_nxt;
  logic [15:0] sig_nxt;

  // num_q-1 wraps 0 -> 3FF, which is exactly N-1 for the 1024-pattern case.
  assign last_pat = (idx_q == (num_q - 10'd1));
  assign pat_nxt  = mode_q ? {pat_q[8:0], pat_q[9] ^ pat_q[6]} : (pat_q + 10'd1);
  assign sig_nxt  = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000)
                    ^ {15'b0, cut_in};

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    num_d   = num_q;
    seed_d  = seed_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    mism_d  = mism_q;
    ffi_d   = ffi_q;
    ffv_d   = ffv_q;
    sig_d   = sig_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          mode_d  = mode;
          num_d   = num_pat;
          // An all-zero LFSR state would lock up, so substitute 001.
          seed_d  = (mode && (seed == 10'd0)) ? 10'h001 : seed;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d = APPLY;
          pat_d   = seed_q;
          idx_d   = 10'd0;
          mism_d  = 11'd0;
          ffi_d   = 10'd0;
          ffv_d   = 1'b0;
          sig_d   = 16'hFFFF;
        end
      end
      APPLY: begin
        state_d = abort ? IDLE : SAMPLE;
      end
      SAMPLE: begin
        // The sample taken in this cycle is committed even if aborting.
        if (golden_in != cut_in) begin
          mism_d = mism_q + 11'd1;
          if (!ffv_q) begin
            ffi_d = idx_q;
            ffv_d = 1'b1;
          end
        end
        sig_d = sig_nxt;
        if (abort) begin
          state_d = IDLE;
        end else if (last_pat) begin
          state_d = DONE;
        end else begin
          state_d = APPLY;
          idx_d   = idx_q + 10'd1;
          pat_d   = pat_nxt;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      num_q   <= 10'd0;
      seed_q  <= 10'd0;
      pat_q   <= 10'd0;
      idx_q   <= 10'd0;
      mism_q  <= 11'd0;
      ffi_q   <= 10'd0;
      ffv_q   <= 1'b0;
      sig_q   <= 16'hFFFF;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      num_q   <= num_d;
      seed_q  <= seed_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      mism_q  <= mism_d;
      ffi_q   <= ffi_d;
      ffv_q   <= ffv_d;
      sig_q   <= sig_d;
    end
  end

  assign pattern        = pat_q;
  assign busy           = (state_q == LOAD) || (state_q == APPLY) || (state_q == SAMPLE);
  assign done           = (state_q == DONE);
  assign mism_cnt       = mism_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_vld = ffv_q;
  assign signature      = sig_q;

endmodule
